// File: rtl/maxpool_22_pkg.sv
// rtl/maxpool_22_pkg.sv - shared constants for the conv -> maxpool pipeline
package maxpool_22_pkg;

  localparam int PIX_DW    = 16;
  localparam int IMG_W     = 220;
  localparam int IMG_H     = 220;
  localparam int K         = 5;
  localparam int CONV_W    = IMG_W - K + 1;
  localparam int CONV_H    = IMG_H - K + 1;
  localparam int POOL_W    = CONV_W / 2;
  localparam int POOL_H    = CONV_H / 2;
  localparam int SAT_LIMIT = 255;

  // Counter width for a 0..n-1 range; never narrower than one bit.
  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int COL_CW  = cw(CONV_W);
  localparam int ROW_CW  = cw(CONV_H);
  localparam int OCOL_CW = cw(POOL_W);
  localparam int OROW_CW = cw(POOL_H);

endpackage

// File: rtl/maxpool_22_if.sv
// rtl/maxpool_22_if.sv - pixel stream in / pooled pixel stream out
interface maxpool_22_if #(
  parameter int DW = 16,
  parameter int CW = 7,
  parameter int RW = 7
);

  logic [DW-1:0] pxl_in;
  logic          valid_in;
  logic [DW-1:0] pxl_out;
  logic [7:0]    pxl_out8;
  logic          valid_out;
  logic          frame_done;
  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;

  modport master (
    output pxl_in, valid_in,
    input  pxl_out, pxl_out8, valid_out, frame_done, out_col, out_row
  );

  modport slave (
    input  pxl_in, valid_in,
    output pxl_out, pxl_out8, valid_out, frame_done, out_col, out_row
  );

endinterface

// File: rtl/maxpool_22_linebuf.sv
// rtl/maxpool_22_linebuf.sv - half-width line of partial maxima, sync write / async read
module pool_linebuf #(
  parameter int DEPTH = 108,
  parameter int DW    = 16,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  // No reset: every entry is written on an even row before the odd row reads it.
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool_22.sv
// rtl/maxpool_22.sv - 2x2 stride-2 max pooling of the convolution magnitude stream
module maxpool_22
  import maxpool_22_pkg::*;
#(
  parameter int IN_W = CONV_W,
  parameter int IN_H = CONV_H,
  parameter int DW   = PIX_DW
) (
  input  logic        clk,
  input  logic        reset,
  maxpool_22_if.slave bus
);

  localparam int OUT_W = IN_W / 2;
  localparam int OUT_H = IN_H / 2;
  localparam int CW    = cw(IN_W);
  localparam int RW    = cw(IN_H);
  localparam int OCW   = cw(OUT_W);
  localparam int ORW   = cw(OUT_H);
  localparam bit ODD_W = (IN_W % 2) != 0;
  localparam bit ODD_H = (IN_H % 2) != 0;

  localparam logic [CW-1:0]  COL_LAST  = CW'(IN_W - 1);
  localparam logic [RW-1:0]  ROW_LAST  = RW'(IN_H - 1);
  localparam logic [OCW-1:0] OCOL_LAST = OCW'(OUT_W - 1);
  localparam logic [ORW-1:0] OROW_LAST = ORW'(OUT_H - 1);
  localparam logic [DW-1:0]  SAT_DW    = DW'(SAT_LIMIT);

  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [DW-1:0]  pair_reg;

  logic           beat;
  logic           col_in;
  logic           row_in;
  logic           lb_we;
  logic           fire;
  logic [OCW-1:0] lb_addr;
  logic [DW-1:0]  lb_rdata;
  logic [DW-1:0]  pair_max;
  logic [DW-1:0]  win_max;
  logic [7:0]     win_sat;
  logic [OCW-1:0] ocol_next;
  logic [ORW-1:0] orow_next;
  logic           fd_next;

  logic [DW-1:0]  pxl_q;
  logic [7:0]     pxl8_q;
  logic           valid_q;
  logic           fd_q;
  logic [OCW-1:0] ocol_q;
  logic [ORW-1:0] orow_q;

  assign beat = bus.valid_in;

  // A trailing odd column/row is counted but never enters a window.
  assign col_in = !(ODD_W && (col == COL_LAST));
  assign row_in = !(ODD_H && (row == ROW_LAST));

  assign lb_we     = beat && col_in && row_in && col[0] && !row[0];
  assign fire      = beat && col_in && row_in && col[0] && row[0];
  assign lb_addr   = OCW'(col >> 1);
  assign ocol_next = OCW'(col >> 1);
  assign orow_next = ORW'(row >> 1);

  // Unsigned compares throughout: 0x8000 is the largest magnitude.
  assign pair_max = (bus.pxl_in > pair_reg) ? bus.pxl_in : pair_reg;
  assign win_max  = (lb_rdata > pair_max) ? lb_rdata : pair_max;
  assign win_sat  = (win_max > SAT_DW) ? 8'hFF : win_max[7:0];
  assign fd_next  = fire && (ocol_next == OCOL_LAST) && (orow_next == OROW_LAST);

  pool_linebuf #(
    .DEPTH (OUT_W),
    .DW    (DW),
    .AW    (OCW)
  ) u_linebuf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (pair_max),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (beat) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pair_reg <= '0;
    end else if (beat && !col[0]) begin
      pair_reg <= bus.pxl_in;
    end
  end

  // Output stage: data/position hold between windows, strobes are single-cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pxl_q   <= '0;
      pxl8_q  <= '0;
      valid_q <= 1'b0;
      fd_q    <= 1'b0;
      ocol_q  <= '0;
      orow_q  <= '0;
    end else begin
      valid_q <= fire;
      fd_q    <= fd_next;
      if (fire) begin
        pxl_q  <= win_max;
        pxl8_q <= win_sat;
        ocol_q <= ocol_next;
        orow_q <= orow_next;
      end
    end
  end

  assign bus.pxl_out    = pxl_q;
  assign bus.pxl_out8   = pxl8_q;
  assign bus.valid_out  = valid_q;
  assign bus.frame_done = fd_q;
  assign bus.out_col    = ocol_q;
  assign bus.out_row    = orow_q;

endmodule
